// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display path.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int BCD_W      = 4;
    localparam int DIGITS_W   = NUM_DIGITS * BCD_W;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } scan_state_t;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t digit_of(
        input logic [DIGITS_W-1:0] d,
        input logic [SEL_W-1:0]    i
    );
        return d[i*BCD_W +: BCD_W];
    endfunction

    // True when digit i and every more significant digit are zero.
    function automatic logic upper_zero(
        input logic [DIGITS_W-1:0] d,
        input logic [SEL_W-1:0]    i
    );
        logic z;
        z = 1'b1;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (n >= int'(i) && d[n*BCD_W +: BCD_W] != '0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV prescaler with a terminal-count strobe.
module tick_divider #(
    parameter int DIV = 100000,
    localparam int W  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic [W-1:0] CNT,
    output logic         TC
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (EN) begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;
    assign TC  = EN && (cnt_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with anti-ghost blanking
// and optional leading-zero suppression.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [DIGITS_W-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0] DP_IN,
    input  logic                BLANK_LEADING,
    output logic [SEL_W-1:0]    SEL,
    output bcd_digit_t          BCD,
    output logic                DP,
    output logic                BLANK,
    output logic                TICK
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BL = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CW-1:0] WEND0 = CW'(BL);

    logic [CW-1:0] cnt;
    logic          tc;

    tick_divider #(
        .DIV (CLK_DIV)
    ) u_div (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .CNT (cnt),
        .TC  (tc)
    );

    scan_state_t      state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    bcd_digit_t       bcd_q;
    logic             dp_q;
    logic             blank_q;
    logic             tick_q;
    logic             zup_q;
    logic             load_q;
    logic [CW-1:0]    wend_q;
    logic [CW-1:0]    wend_d;
    logic             supp_now;
    logic             supp_adv;

    assign sel_d    = sel_q + 1'b1;
    // A resumed window is measured from the frozen count, not from zero.
    assign wend_d   = CW'((int'(cnt) + BL) % CLK_DIV);
    assign supp_now = BLANK_LEADING && (sel_q != '0) && zup_q;
    assign supp_adv = BLANK_LEADING && (sel_d != '0)
                   && upper_zero(DIGITS, sel_d);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_BLANK;
            sel_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= 1'b0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
            zup_q   <= 1'b0;
            load_q  <= 1'b1;
            wend_q  <= WEND0;
        end else if (!EN) begin
            state_q <= S_BLANK;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
            wend_q  <= wend_d;
        end else if (tc) begin
            sel_q  <= sel_d;
            bcd_q  <= digit_of(DIGITS, sel_d);
            dp_q   <= DP_IN[sel_d];
            zup_q  <= upper_zero(DIGITS, sel_d);
            tick_q <= 1'b1;
            load_q <= 1'b0;
            wend_q <= WEND0;
            if (BLANK_CYCLES == 0) begin
                state_q <= S_SHOW;
                blank_q <= supp_adv;
            end else begin
                state_q <= S_BLANK;
                blank_q <= 1'b1;
            end
        end else begin
            tick_q <= 1'b0;
            // Digit 0 is captured once after reset; later digits at advance.
            if (load_q) begin
                bcd_q  <= digit_of(DIGITS, sel_q);
                dp_q   <= DP_IN[sel_q];
                zup_q  <= upper_zero(DIGITS, sel_q);
                load_q <= 1'b0;
            end
            unique case (state_q)
                S_BLANK: begin
                    if (BLANK_CYCLES == 0 || cnt == wend_q) begin
                        state_q <= S_SHOW;
                        blank_q <= supp_now;
                    end
                end
                S_SHOW: begin
                    blank_q <= supp_now;
                end
            endcase
        end
    end

    assign SEL   = sel_q;
    assign BCD   = bcd_q;
    assign DP    = dp_q;
    assign BLANK = blank_q;
    assign TICK  = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised and directed bench for display_scan_ctrl against a
// cycle-level behavioural model of the scan rules.
module tb_display_scan_ctrl;

    localparam int DIV = 8;
    localparam int BC  = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic        BLANK_LEADING;
    logic [1:0]  SEL;
    logic [3:0]  BCD;
    logic        DP;
    logic        BLANK;
    logic        TICK;

    always #5 CLK = ~CLK;

    display_scan_ctrl #(
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .EN            (EN),
        .DIGITS        (DIGITS),
        .DP_IN         (DP_IN),
        .BLANK_LEADING (BLANK_LEADING),
        .SEL           (SEL),
        .BCD           (BCD),
        .DP            (DP),
        .BLANK         (BLANK),
        .TICK          (TICK)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: prescaler phase, digit index, blank cycles left,
    // and a full copy of the digits captured at the last advance.
    int          m_p;
    int          m_idx;
    int          m_left;
    bit          m_forced;
    bit          m_pend;
    logic        m_tick;
    logic [15:0] m_snap;
    logic [3:0]  m_snapdp;
    logic [3:0]  m_bcd;
    logic        m_dp;
    logic        m_blank;

    function automatic bit lead_zero(input logic [15:0] s, input int idx);
        for (int k = idx; k < 4; k++) begin
            if (((s >> (4 * k)) & 16'h000F) != 16'h0000) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RST) begin
            m_p = 0; m_idx = 0; m_left = BC; m_forced = 1; m_pend = 1;
            m_tick = 0; m_snap = '0; m_snapdp = '0;
            m_bcd = '0; m_dp = 0; m_blank = 1;
        end else if (!EN) begin
            m_forced = 1; m_left = BC; m_tick = 0; m_blank = 1;
        end else begin
            m_tick = 0;
            m_forced = 0;
            if (m_p == DIV - 1) begin
                m_p = 0;
                m_idx = (m_idx + 1) % 4;
                m_snap = DIGITS;
                m_snapdp = DP_IN;
                m_pend = 0;
                m_tick = 1;
                m_left = BC;
            end else begin
                if (m_pend) begin
                    m_snap = DIGITS;
                    m_snapdp = DP_IN;
                    m_pend = 0;
                end
                m_p++;
                if (m_left > 0) m_left--;
            end
            m_bcd = 4'((m_snap >> (4 * m_idx)) & 16'h000F);
            m_dp = m_snapdp[m_idx];
            m_blank = m_forced || (m_left > 0)
                   || (BLANK_LEADING && m_idx != 0 && lead_zero(m_snap, m_idx));
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        int ticks;
        logic [1:0] exp_sel [5];
        logic [3:0] exp_bcd [5];
        exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_bcd = '{4'h3, 4'h2, 4'h1, 4'h4, 4'h3};
        DIGITS = 16'h1234; DP_IN = 4'b0100; BLANK_LEADING = 0; EN = 1;
        do_reset();
        n_chk++;
        if ({SEL, BCD, DP, BLANK, TICK} !== {2'd0, 4'h0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state: sel=%0d bcd=%h dp=%b blank=%b tick=%b, expected 0 0 0 1 0",
                     SEL, BCD, DP, BLANK, TICK);
        else n_pass++;
        ticks = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL scan c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
            if (c == 2) begin
                n_chk++;
                if ({BCD, BLANK} !== {4'h4, 1'b0})
                    $display("FAIL first_show: bcd=%h blank=%b, expected 4 0", BCD, BLANK);
                else n_pass++;
            end
            if (c % DIV == 0) begin
                n_chk++;
                if ({TICK, SEL, BCD} !== {1'b1, exp_sel[ticks], exp_bcd[ticks]})
                    $display("FAIL tick_seq c=%0d: tick=%b sel=%0d bcd=%h, expected 1 %0d %h",
                             c, TICK, SEL, BCD, exp_sel[ticks], exp_bcd[ticks]);
                else n_pass++;
                ticks++;
            end
        end
    endtask

    task automatic test_leading_zeros();
        int vis [4];
        logic [15:0] pat  [3];
        logic        bl   [3];
        int          want [3][4];
        pat  = '{16'h0070, 16'h0070, 16'h0000};
        bl   = '{1'b1, 1'b0, 1'b1};
        want = '{'{6, 6, 0, 0}, '{6, 6, 6, 6}, '{6, 0, 0, 0}};
        for (int s = 0; s < 3; s++) begin
            DIGITS = pat[s]; BLANK_LEADING = bl[s]; EN = 1; DP_IN = '0;
            do_reset();
            vis = '{0, 0, 0, 0};
            for (int c = 1; c < 32; c++) begin
                step();
                n_chk++;
                if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                    $display("FAIL lead s=%0d c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                             s, c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
                else n_pass++;
                if (BLANK === 1'b0) vis[SEL]++;
            end
            for (int d = 0; d < 4; d++) begin
                n_chk++;
                if (vis[d] != want[s][d])
                    $display("FAIL lead_visible s=%0d digit=%0d: %0d cycles, expected %0d",
                             s, d, vis[d], want[s][d]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_snapshot();
        DIGITS = 16'h1234; DP_IN = '0; BLANK_LEADING = 0; EN = 1;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 12) DIGITS = 16'h9999;
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL snap c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
            if (c == 15 || c == 16) begin
                n_chk++;
                if (BCD !== ((c == 15) ? 4'h3 : 4'h9))
                    $display("FAIL snap_hold c=%0d: bcd=%h, expected %h",
                             c, BCD, (c == 15) ? 4'h3 : 4'h9);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable();
        int bad;
        DIGITS = 16'h1234; DP_IN = '0; BLANK_LEADING = 0; EN = 1;
        do_reset();
        for (int c = 1; c <= 21; c++) step();
        EN = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL en_off c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
            if (SEL !== 2'd2 || TICK !== 1'b0 || BLANK !== 1'b1) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL en_hold: %0d bad cycles, expected 0", bad);
        else n_pass++;
        EN = 1;
        step();
        n_chk++;
        if ({BLANK, TICK} !== 2'b10)
            $display("FAIL en_resume1: blank=%b tick=%b, expected 1 0", BLANK, TICK);
        else n_pass++;
        step();
        n_chk++;
        if ({BLANK, TICK, SEL} !== {2'b00, 2'd2})
            $display("FAIL en_resume2: blank=%b tick=%b sel=%0d, expected 0 0 2", BLANK, TICK, SEL);
        else n_pass++;
        step();
        n_chk++;
        if ({BLANK, TICK, SEL, BCD} !== {2'b11, 2'd3, 4'h1})
            $display("FAIL en_advance: blank=%b tick=%b sel=%0d bcd=%h, expected 1 1 3 1",
                     BLANK, TICK, SEL, BCD);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        DIGITS = 16'h1234; DP_IN = 4'b1111; BLANK_LEADING = 0; EN = 1;
        do_reset();
        for (int c = 1; c <= 31; c++) step();
        RST = 1;
        step();
        RST = 0;
        n_chk++;
        if ({SEL, BLANK, TICK, BCD, DP} !== {2'd0, 1'b1, 1'b0, 4'h0, 1'b0})
            $display("FAIL reset_mid: sel=%0d blank=%b tick=%b bcd=%h dp=%b, expected 0 1 0 0 0",
                     SEL, BLANK, TICK, BCD, DP);
        else n_pass++;
        for (int c = 1; c <= 16; c++) begin
            step();
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL reset_mid_run c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int ticks;
        int last;
        int bad;
        DIGITS = 16'h5678; DP_IN = 4'b0001; BLANK_LEADING = 0; EN = 1;
        do_reset();
        ticks = 0; last = 0; bad = 0;
        for (int c = 1; c <= 1000 * DIV; c++) begin
            step();
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL wrap c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
            if (TICK === 1'b1) begin
                ticks++;
                if (c - last != DIV || SEL !== 2'(ticks % 4)) bad++;
                last = c;
            end
        end
        n_chk++;
        if (ticks != 1000 || bad != 0)
            $display("FAIL wrap_ticks: %0d ticks %0d bad, expected 1000 ticks 0 bad", ticks, bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        DIGITS = 16'h0000; DP_IN = '0; BLANK_LEADING = 1; EN = 1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            EN = ($urandom_range(0, 9) != 0);
            RST = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) begin
                for (int k = 0; k < 4; k++)
                    d[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                DIGITS = d;
                DP_IN = 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) BLANK_LEADING = ~BLANK_LEADING;
            step();
            n_chk++;
            if ({SEL, BCD, DP, BLANK, TICK} !== {2'(m_idx), m_bcd, m_dp, m_blank, m_tick})
                $display("FAIL random c=%0d: got %0d %h %b %b %b, expected %0d %h %b %b %b",
                         c, SEL, BCD, DP, BLANK, TICK, m_idx, m_bcd, m_dp, m_blank, m_tick);
            else n_pass++;
        end
        RST = 0;
    endtask

    initial begin
        RST = 1; EN = 0; DIGITS = '0; DP_IN = '0; BLANK_LEADING = 0;
        test_reset();
        test_leading_zeros();
        test_snapshot();
        test_enable();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
